// File: rtl/cpu_core_param.sv
// cpu_core_param: parametrised multi-cycle core with external synchronous
// instruction memory, req/ack data memory, flag branches and halt/error stop.
module cpu_core_param #(
  parameter  int DW   = 8,
  parameter  int AW   = 4,
  parameter  int RSW  = 2,
  localparam int IW   = 4 + RSW + AW,
  localparam int NREG = 2 ** RSW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  output logic          im_en_o,
  output logic [AW-1:0] im_addr_o,
  input  logic [IW-1:0] im_data_i,
  output logic          dm_req_o,
  output logic          dm_we_o,
  output logic [AW-1:0] dm_addr_o,
  output logic [DW-1:0] dm_wdata_o,
  input  logic [DW-1:0] dm_rdata_i,
  input  logic          dm_ack_i,
  output logic [DW-1:0] out_data_o,
  output logic          out_valid_o,
  output logic [AW-1:0] pc_o,
  output logic          halted_o,
  output logic          err_o
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t          state;
  logic [AW-1:0]   pc;
  logic [IW-1:0]   ir;
  logic [DW-1:0]   regs [NREG];
  logic            z, n, c;

  logic [3:0]      op;
  logic [RSW-1:0]  rd;
  logic [AW-1:0]   f;
  logic [RSW-1:0]  rs;

  assign op = ir[IW-1 -: 4];
  assign rd = ir[AW +: RSW];
  assign f  = ir[AW-1:0];
  assign rs = f[RSW-1:0];

  logic op_ldi, op_ld, op_st, op_add, op_sub;
  logic op_and, op_or, op_jmp, op_jz, op_jn;
  logic op_jc, op_out, op_hlt, op_ill;
  logic is_alu, is_br, is_mem, take;

  assign op_ldi = op == 4'd1;
  assign op_ld  = op == 4'd2;
  assign op_st  = op == 4'd3;
  assign op_add = op == 4'd4;
  assign op_sub = op == 4'd5;
  assign op_and = op == 4'd6;
  assign op_or  = op == 4'd7;
  assign op_jmp = op == 4'd8;
  assign op_jz  = op == 4'd9;
  assign op_jn  = op == 4'd10;
  assign op_jc  = op == 4'd11;
  assign op_out = op == 4'd12;
  assign op_hlt = op == 4'd13;
  assign op_ill = op[3:1] == 3'b111;

  assign is_alu = op_add | op_sub | op_and | op_or;
  assign is_br  = op_jmp | op_jz | op_jn | op_jc;
  assign is_mem = op_ld | op_st;
  assign take   = op_jmp | (op_jz & z)
                | (op_jn & n) | (op_jc & c);

  logic [DW-1:0] ra, rb, alu_r;
  logic          alu_c;

  assign ra = regs[rd];
  assign rb = regs[rs];

  // Borrow of SUB falls out as bit DW of the widened difference
  always_comb begin
    alu_r = '0;
    alu_c = 1'b0;
    unique case (1'b1)
      op_add:  {alu_c, alu_r} = {1'b0, ra} + {1'b0, rb};
      op_sub:  {alu_c, alu_r} = {1'b0, ra} - {1'b0, rb};
      op_and:  alu_r = ra & rb;
      default: alu_r = ra | rb;
    endcase
  end

  // Strobes are gated by reset so they drop the moment reset asserts
  assign im_en_o    = rst_i & (state == S_FETCH) & en_i;
  assign im_addr_o  = pc;
  assign dm_req_o   = rst_i & (state == S_MEM);
  assign dm_we_o    = dm_req_o & op_st;
  assign dm_addr_o  = f;
  assign dm_wdata_o = ra;
  assign pc_o       = pc;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= S_FETCH;
      pc          <= '0;
      ir          <= '0;
      z           <= 1'b0;
      n           <= 1'b0;
      c           <= 1'b0;
      out_data_o  <= '0;
      out_valid_o <= 1'b0;
      halted_o    <= 1'b0;
      err_o       <= 1'b0;
      for (int i = 0; i < NREG; i++)
        regs[i] <= '0;
    end else begin
      out_valid_o <= 1'b0;
      unique case (state)
        S_FETCH: begin
          if (en_i)
            state <= S_DECODE;
        end
        S_DECODE: begin
          ir    <= im_data_i;
          pc    <= pc + AW'(1);
          state <= S_EXEC;
        end
        S_EXEC: begin
          state <= S_FETCH;
          unique case (1'b1)
            is_alu: begin
              regs[rd] <= alu_r;
              z        <= alu_r == '0;
              n        <= alu_r[DW-1];
              c        <= alu_c;
            end
            op_ldi: regs[rd] <= DW'(f);
            is_br: begin
              if (take)
                pc <= f;
            end
            op_out: begin
              out_data_o  <= ra;
              out_valid_o <= 1'b1;
            end
            is_mem: state <= S_MEM;
            op_hlt: begin
              halted_o <= 1'b1;
              state    <= S_HALT;
            end
            op_ill: begin
              halted_o <= 1'b1;
              err_o    <= 1'b1;
              state    <= S_HALT;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (dm_ack_i) begin
            if (op_ld)
              regs[rd] <= dm_rdata_i;
            state <= S_FETCH;
          end
        end
        default: state <= S_HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core_param.sv
// tb_cpu_core_param: directed programs with hand-computed results for
// cpu_core_param at default parameters (DW=8, AW=4, RSW=2).
module tb_cpu_core_param;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  logic       en_i = 1'b1;
  logic       im_en_o;
  logic [3:0] im_addr_o;
  logic [9:0] im_data;
  logic       dm_req_o, dm_we_o;
  logic [3:0] dm_addr_o;
  logic [7:0] dm_wdata_o;
  logic [7:0] dm_rdata = 8'h00;
  logic       dm_ack_i;
  logic [7:0] out_data_o;
  logic       out_valid_o;
  logic [3:0] pc_o;
  logic       halted_o, err_o;

  cpu_core_param dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .en_i        (en_i),
    .im_en_o     (im_en_o),
    .im_addr_o   (im_addr_o),
    .im_data_i   (im_data),
    .dm_req_o    (dm_req_o),
    .dm_we_o     (dm_we_o),
    .dm_addr_o   (dm_addr_o),
    .dm_wdata_o  (dm_wdata_o),
    .dm_rdata_i  (dm_rdata),
    .dm_ack_i    (dm_ack_i),
    .out_data_o  (out_data_o),
    .out_valid_o (out_valid_o),
    .pc_o        (pc_o),
    .halted_o    (halted_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  logic [9:0] imem [16];
  int         ack_dly = 1;
  bit         ack_en = 1'b1;
  bit         exp_we = 1'b0;
  logic [3:0] exp_addr = 4'h0;

  int         wait_cnt;
  int         out_cnt, req_cyc, im_cnt;
  logic [7:0] out_first, out_last, out_or;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  bit         bad_attr, overlap;

  int n_checks = 0;
  int n_fail = 0;

  always @(posedge clk)
    if (im_en_o) im_data <= imem[im_addr_o];

  assign dm_ack_i = dm_req_o & ack_en
                  & (wait_cnt == ack_dly - 1);

  always @(posedge clk) begin
    if (!rst_i) begin
      wait_cnt  <= 0;
      out_cnt   <= 0;
      req_cyc   <= 0;
      im_cnt    <= 0;
      out_first <= '0;
      out_last  <= '0;
      out_or    <= '0;
      wr_addr   <= '0;
      wr_data   <= '0;
      bad_attr  <= 1'b0;
      overlap   <= 1'b0;
    end else begin
      wait_cnt <= (dm_req_o && !dm_ack_i) ? wait_cnt + 1 : 0;
      if (out_valid_o) begin
        out_cnt  <= out_cnt + 1;
        out_last <= out_data_o;
        out_or   <= out_or | out_data_o;
        if (out_cnt == 0) out_first <= out_data_o;
      end
      if (dm_req_o) begin
        req_cyc <= req_cyc + 1;
        if (dm_we_o !== exp_we || dm_addr_o !== exp_addr)
          bad_attr <= 1'b1;
      end
      if (dm_req_o && im_en_o) overlap <= 1'b1;
      if (im_en_o) im_cnt <= im_cnt + 1;
      if (dm_req_o && dm_ack_i && dm_we_o) begin
        wr_addr <= dm_addr_o;
        wr_data <= dm_wdata_o;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [9:0] enc(input int op,
                                     input int r,
                                     input int f);
    enc = {4'(op), 2'(r), 4'(f)};
  endfunction

  localparam logic [9:0] ILL = 10'h380;

  task automatic fill(input logic [9:0] w);
    for (int i = 0; i < 16; i++) imem[i] = w;
  endtask

  task automatic cyc(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b0;
    en_i  = 1'b1;
    @(posedge clk);
    #1;
    check("rst_pc", pc_o, 0);
    check("rst_halt", halted_o, 0);
    check("rst_err", err_o, 0);
    check("rst_outd", out_data_o, 0);
    check("rst_outv", out_valid_o, 0);
    check("rst_imen", im_en_o, 0);
    check("rst_req", dm_req_o, 0);
    @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
  endtask

  int n0;

  initial begin
    // ADD then OUT then HALT, 5 instructions x 3 cycles
    fill(ILL);
    imem[0] = enc(1, 0, 5);
    imem[1] = enc(1, 1, 3);
    imem[2] = enc(4, 0, 1);
    imem[3] = enc(12, 0, 0);
    imem[4] = enc(13, 0, 0);
    do_reset();
    cyc(14);
    check("add_halt14", halted_o, 0);
    cyc(1);
    check("add_halt15", halted_o, 1);
    check("add_err", err_o, 0);
    check("add_outcnt", out_cnt, 1);
    check("add_out", out_last, 8);
    check("add_pc", pc_o, 5);

    // flags after 5+3: no branch may be taken
    fill(ILL);
    imem[0] = enc(1, 0, 5);
    imem[1] = enc(1, 1, 3);
    imem[2] = enc(4, 0, 1);
    imem[3] = enc(9, 0, 15);
    imem[4] = enc(10, 0, 15);
    imem[5] = enc(11, 0, 15);
    imem[6] = enc(12, 0, 0);
    imem[7] = enc(13, 0, 0);
    do_reset();
    cyc(24);
    check("flg_halt", halted_o, 1);
    check("flg_err", err_o, 0);
    check("flg_out", out_last, 8);

    // 2-3 borrows: 0xFF, C=1, N=1, Z=0
    fill(ILL);
    imem[0]  = enc(1, 0, 2);
    imem[1]  = enc(1, 1, 3);
    imem[2]  = enc(5, 0, 1);
    imem[3]  = enc(11, 0, 7);
    imem[7]  = enc(10, 0, 10);
    imem[10] = enc(9, 0, 15);
    imem[11] = enc(12, 0, 0);
    imem[12] = enc(13, 0, 0);
    do_reset();
    cyc(12);
    check("sub_jc_pc", pc_o, 7);
    cyc(15);
    check("sub_halt", halted_o, 1);
    check("sub_err", err_o, 0);
    check("sub_out", out_last, 8'hFF);

    // 3-3: zero, C=0, N=0
    fill(ILL);
    imem[0] = enc(1, 0, 3);
    imem[1] = enc(1, 1, 3);
    imem[2] = enc(5, 0, 1);
    imem[3] = enc(11, 0, 15);
    imem[4] = enc(9, 0, 6);
    imem[6] = enc(10, 0, 15);
    imem[7] = enc(12, 0, 0);
    imem[8] = enc(13, 0, 0);
    do_reset();
    cyc(12);
    check("subz_pc", pc_o, 4);
    cyc(12);
    check("subz_halt", halted_o, 1);
    check("subz_err", err_o, 0);
    check("subz_out", out_last, 0);

    // doubling 15 to 480 carries out; AND with R1=0 sets Z, clears C
    fill(ILL);
    imem[0]  = enc(1, 0, 15);
    imem[1]  = enc(4, 0, 0);
    imem[2]  = enc(4, 0, 0);
    imem[3]  = enc(4, 0, 0);
    imem[4]  = enc(4, 0, 0);
    imem[5]  = enc(4, 0, 0);
    imem[6]  = enc(11, 0, 8);
    imem[8]  = enc(12, 0, 0);
    imem[9]  = enc(6, 0, 1);
    imem[10] = enc(11, 0, 15);
    imem[11] = enc(9, 0, 13);
    imem[13] = enc(12, 0, 0);
    imem[14] = enc(13, 0, 0);
    do_reset();
    cyc(39);
    check("cy_halt", halted_o, 1);
    check("cy_err", err_o, 0);
    check("cy_outcnt", out_cnt, 2);
    check("cy_first", out_first, 8'hE0);
    check("cy_last", out_last, 0);

    // LD with ack in the third MEM cycle
    fill(ILL);
    imem[0] = enc(2, 2, 10);
    imem[1] = enc(12, 2, 0);
    imem[2] = enc(13, 0, 0);
    ack_dly  = 3;
    ack_en   = 1'b1;
    exp_we   = 1'b0;
    exp_addr = 4'hA;
    dm_rdata = 8'h5C;
    do_reset();
    cyc(11);
    check("ld_halt11", halted_o, 0);
    cyc(1);
    check("ld_halt12", halted_o, 1);
    check("ld_reqcyc", req_cyc, 3);
    check("ld_attr", bad_attr, 0);
    check("ld_overlap", overlap, 0);
    check("ld_out", out_last, 8'h5C);

    // ST with immediate ack
    fill(ILL);
    imem[0] = enc(1, 3, 7);
    imem[1] = enc(3, 3, 5);
    imem[2] = enc(13, 0, 0);
    ack_dly  = 1;
    exp_we   = 1'b1;
    exp_addr = 4'h5;
    do_reset();
    cyc(10);
    check("st_halt", halted_o, 1);
    check("st_reqcyc", req_cyc, 1);
    check("st_attr", bad_attr, 0);
    check("st_waddr", wr_addr, 5);
    check("st_wdata", wr_data, 7);

    // NOP sweep wraps PC, then en_i gating
    fill(10'h000);
    do_reset();
    cyc(45);
    check("wrap_pc15", pc_o, 15);
    cyc(3);
    check("wrap_pc0", pc_o, 0);
    en_i = 1'b0;
    n0 = im_cnt;
    cyc(4);
    check("en_imcnt", im_cnt, n0);
    check("en_imen", im_en_o, 0);
    check("en_pc", pc_o, 0);
    en_i = 1'b1;
    #1;
    check("en_resume", im_en_o, 1);
    check("en_addr", im_addr_o, 0);

    // illegal opcode at address 2
    fill(10'h000);
    imem[2] = enc(14, 0, 0);
    do_reset();
    cyc(8);
    check("ill_halt8", halted_o, 0);
    cyc(1);
    check("ill_halt9", halted_o, 1);
    check("ill_err", err_o, 1);
    check("ill_pc", pc_o, 3);
    n0 = im_cnt;
    for (int i = 0; i < 6; i++) begin
      en_i = ~en_i;
      cyc(1);
    end
    check("ill_imcnt", im_cnt, n0);
    check("ill_req", req_cyc, 0);
    check("ill_still", err_o, 1);

    // reset during an unacknowledged ST
    fill(ILL);
    imem[0] = enc(1, 1, 9);
    imem[1] = enc(1, 2, 4);
    imem[2] = enc(3, 1, 3);
    ack_en   = 1'b0;
    exp_we   = 1'b1;
    exp_addr = 4'h3;
    do_reset();
    cyc(11);
    check("strst_req", dm_req_o, 1);
    check("strst_reqcyc", req_cyc, 2);
    check("strst_attr", bad_attr, 0);
    #2;
    rst_i = 1'b0;
    #1;
    check("strst_reqdrop", dm_req_o, 0);
    check("strst_pc", pc_o, 0);
    fill(ILL);
    imem[0] = enc(12, 1, 0);
    imem[1] = enc(12, 2, 0);
    imem[2] = enc(13, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    #1;
    check("strst_imen", im_en_o, 1);
    check("strst_imaddr", im_addr_o, 0);
    cyc(9);
    check("strst_halt", halted_o, 1);
    check("strst_err", err_o, 0);
    check("strst_outcnt", out_cnt, 2);
    check("strst_regs", out_or, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cpu_core_param.md
Name: cpu_core_param

Overview:
- Parametrised multi-cycle CPU core; next generation of the 8-bit cpu8bit core.
- Generalised in data width, address width and register count.
- Adds conditional branches on Z/N/C flags, an ack-handshaked data-memory port, an output port with a valid strobe, and HALT/illegal-opcode detection.
- Instruction memory is external with synchronous read; data memory is external with req/ack handshake.

Parameters:
- DW, 8: data/register width.
- AW, 4: instruction- and data-address width; PC width; must satisfy AW >= RSW.
- RSW, 2: register-select width; NREG = 2**RSW.
- IW is derived as 4+RSW+AW, default 10.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- en_i  in  1  run enable; sampled only in FETCH.
- im_en_o  out  1  instruction-memory read strobe.
- im_addr_o  out  AW  instruction address (= PC).
- im_data_i  in  IW  instruction word; valid the cycle after im_en_o.
- dm_req_o  out  1  data-memory request.
- dm_we_o  out  1  1 = write, 0 = read.
- dm_addr_o  out  AW  data address.
- dm_wdata_o  out  DW  write data.
- dm_rdata_i  in  DW  read data; valid when dm_ack_i = 1.
- dm_ack_i  in  1  request complete.
- out_data_o  out  DW  last OUT value.
- out_valid_o  out  1  one-cycle pulse per OUT.
- pc_o  out  AW  current PC.
- halted_o  out  1  core halted.
- err_o  out  1  halted on illegal opcode.

Behaviour:
- Reset (rst_i = 0, asynchronous): PC, all registers, flags Z/N/C, IR, out_data_o = 0; all strobes 0; halted_o = err_o = 0; state = FETCH.
- Instruction format: IR = {op[3:0], r[RSW-1:0], f[AW-1:0]}. rs = f[RSW-1:0]. Immediates are zero-extended to DW.
- Opcodes:
  - 0 NOP
  - 1 LDI: R[r] = f
  - 2 LD: R[r] = DM[f]
  - 3 ST: DM[f] = R[r]
  - 4 ADD: R[r] = R[r] + R[rs]
  - 5 SUB: R[r] = R[r] - R[rs]
  - 6 AND
  - 7 OR
  - 8 JMP f
  - 9 JZ f
  - 10 JN f
  - 11 JC f
  - 12 OUT R[r]
  - 13 HALT
  - 14-15 illegal
- FSM states: FETCH, DECODE, EXEC, MEM, HALT.
- FETCH: im_en_o = 1 with im_addr_o = PC only when en_i = 1, then go to DECODE. If en_i = 0, hold with im_en_o = 0.
- DECODE: IR <= im_data_i; PC <= PC+1 (wraps 2**AW-1 -> 0); go to EXEC.
- EXEC, one cycle:
  - ALU ops write R[r] and update flags; go to FETCH.
  - Jumps load PC <= f if the condition holds, else PC is unchanged; go to FETCH.
  - OUT: out_data_o <= R[r], out_valid_o = 1 for this cycle only; go to FETCH.
  - LD/ST go to MEM.
  - HALT: halted_o = 1, go to HALT.
  - Illegal: halted_o = err_o = 1, go to HALT.
- Flags:
  - Only ADD, SUB, AND and OR update flags. LDI, LD and other ops leave them unchanged.
  - Z = (result == 0); N = result[DW-1].
  - ADD: C = carry-out of the DW-bit sum.
  - SUB: C = borrow, i.e. 1 iff R[r] < R[rs] unsigned.
  - AND/OR: C = 0.
  - All results are truncated to DW.
- Register aliasing: rs == r is legal (e.g. SUB r,r gives 0 with Z = 1). Reads use pre-EXEC values.
- MEM:
  - dm_req_o = 1; dm_we_o, dm_addr_o = f and dm_wdata_o = R[r] are held stable until the ack cycle.
  - On dm_ack_i = 1: LD writes R[r] <= dm_rdata_i; drop dm_req_o the next cycle; go to FETCH.
  - Unlimited wait is allowed; no timeout.
  - dm_ack_i outside MEM is ignored.
- HALT: terminal state. Only reset exits it. en_i is ignored. No memory strobes are driven.
- Latency: non-memory instruction = 3 cycles (FETCH, DECODE, EXEC) with en_i = 1. LD/ST = 3 + k cycles, where ack arrives in the k-th MEM cycle (k >= 1).
- en_i deassertion mid-instruction has no effect; it only gates the next FETCH.
- Reset mid-MEM: dm_req_o drops immediately (asynchronously), the LD does not commit, and the core restarts at PC = 0.
- dm_req_o and im_en_o are never asserted simultaneously.

Test Plan:
- Default params, program LDI R0,5; LDI R1,3; ADD R0,R1; OUT R0; HALT -> out_valid_o pulses once with out_data_o = 8; Z = N = C = 0; halted_o = 1 after 15 cycles; err_o = 0.
- LDI R0,2; LDI R1,3; SUB R0,R1; JC 7 -> R0 = 0xFF, N = 1, C = 1; PC jumps to 7. Repeat with R0 = 3: result 0, Z = 1, C = 0; no jump, PC = 4.
- LD R2,0xA with dm_ack_i delayed 3 cycles, rdata = 0x5C -> dm_req_o high 3 cycles, dm_we_o = 0, dm_addr_o = 0xA, R2 = 0x5C; OUT shows 0x5C.
- Program of NOPs filling address 15 -> PC wraps to 0 after address 15. Hold en_i = 0 for 4 cycles -> im_en_o stays 0 and PC is frozen.
- Opcode 14 at address 2 -> halted_o = err_o = 1 after its EXEC. Further en_i toggling produces no im_en_o.
- Reset asserted during a ST wait -> dm_req_o = 0 asynchronously, pc_o = 0, all registers 0. After release, fetch restarts at address 0.
